// File: rtl/sigmoid_lut_q88.sv
// sigmoid_lut_q88: two-stage pipelined logistic sigmoid for signed Q8.8 data.
// Stage 1 folds the operand to |x| and splits it into ROM index, fraction and
// a saturation flag. Stage 2 looks up the positive half and mirrors it for
// negative inputs, so out(-x) = 256 - out(x) holds exactly.
// Build option: define SIGMOID_INTERP_EN for linear interpolation between
// ROM entries. Otherwise the lookup is nearest-lower and the fraction is ignored.
module sigmoid_lut_q88 #(
  parameter int DATA_W    = 16,
  parameter int LUT_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_val,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_val
);

  localparam int IDX_W = $clog2(LUT_DEPTH);
  localparam logic [8:0] ONE_Q = 9'd256;
  // |x| at or above 8.0 is pinned to 1.0 (or 0.0 after mirroring).
  localparam logic [DATA_W:0] SAT_TH = 17'h00800;

  // round(256 / (1 + exp(-k/16))). The extra entry at LUT_DEPTH is the
  // upper interpolation endpoint for the last segment.
  localparam logic [8:0] LUT [0:LUT_DEPTH] = '{
    9'd128, 9'd132, 9'd136, 9'd140, 9'd144, 9'd148, 9'd152, 9'd156,
    9'd159, 9'd163, 9'd167, 9'd170, 9'd174, 9'd177, 9'd181, 9'd184,
    9'd187, 9'd190, 9'd193, 9'd196, 9'd199, 9'd202, 9'd204, 9'd207,
    9'd209, 9'd212, 9'd214, 9'd216, 9'd218, 9'd220, 9'd222, 9'd224,
    9'd225, 9'd227, 9'd229, 9'd230, 9'd232, 9'd233, 9'd234, 9'd235,
    9'd237, 9'd238, 9'd239, 9'd240, 9'd241, 9'd241, 9'd242, 9'd243,
    9'd244, 9'd245, 9'd245, 9'd246, 9'd246, 9'd247, 9'd248, 9'd248,
    9'd248, 9'd249, 9'd249, 9'd250, 9'd250, 9'd250, 9'd251, 9'd251,
    9'd251, 9'd252, 9'd252, 9'd252, 9'd252, 9'd253, 9'd253, 9'd253,
    9'd253, 9'd253, 9'd254, 9'd254, 9'd254, 9'd254, 9'd254, 9'd254,
    9'd254, 9'd254, 9'd254, 9'd255, 9'd255, 9'd255, 9'd255, 9'd255,
    9'd255, 9'd255, 9'd255, 9'd255, 9'd255, 9'd255, 9'd255, 9'd255,
    9'd255, 9'd255, 9'd255, 9'd255, 9'd256, 9'd256, 9'd256, 9'd256,
    9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256,
    9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256,
    9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256, 9'd256,
    9'd256
  };

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic             s1_sat_q,   s1_sat_d;
  logic [IDX_W-1:0] s1_idx_q,   s1_idx_d;
`ifdef SIGMOID_INTERP_EN
  logic [3:0]       s1_frac_q,  s1_frac_d;
  logic [8:0]       lut_hi_s;
  logic [12:0]      prod_s;
  logic [8:0]       interp_s;
`endif

  // Stage 2 state
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_val_q,   out_val_d;

  // Stage 1 combinational helpers
  logic [DATA_W:0] in_ext_s;
  logic [DATA_W:0] mag_s;
  logic [8:0]      lut_lo_s;
  logic [8:0]      tbl_s;
  logic [8:0]      pos_s;
  logic [8:0]      res_s;

  // Fold the operand to a 17-bit magnitude and split it for the lookup.
  always_comb begin
    in_ext_s   = {in_val[DATA_W-1], in_val};
    mag_s      = in_ext_s;
    s1_valid_d = in_valid;
    s1_sign_d  = s1_sign_q;
    s1_sat_d   = s1_sat_q;
    s1_idx_d   = s1_idx_q;
`ifdef SIGMOID_INTERP_EN
    s1_frac_d  = s1_frac_q;
`endif
    if (in_val[DATA_W-1]) begin
      mag_s = -in_ext_s;
    end else begin
      mag_s = in_ext_s;
    end
    if (in_valid) begin
      s1_sign_d = in_val[DATA_W-1];
      s1_sat_d  = (mag_s >= SAT_TH);
      s1_idx_d  = mag_s[10:4];
`ifdef SIGMOID_INTERP_EN
      s1_frac_d = mag_s[3:0];
`endif
    end else begin
      s1_sign_d = s1_sign_q;
      s1_sat_d  = s1_sat_q;
      s1_idx_d  = s1_idx_q;
    end
  end

  // Look up the positive half, saturate, then mirror for negative inputs.
  always_comb begin
    lut_lo_s = LUT[{1'b0, s1_idx_q}];
`ifdef SIGMOID_INTERP_EN
    lut_hi_s = LUT[{1'b0, s1_idx_q} + 8'd1];
    prod_s   = {4'd0, lut_hi_s - lut_lo_s} * {9'd0, s1_frac_q};
    interp_s = 9'(prod_s >> 4);
    tbl_s    = lut_lo_s + interp_s;
`else
    tbl_s    = lut_lo_s;
`endif
    pos_s       = tbl_s;
    res_s       = tbl_s;
    out_valid_d = s1_valid_q;
    out_val_d   = out_val_q;
    if (s1_sat_q) begin
      pos_s = ONE_Q;
    end else begin
      pos_s = tbl_s;
    end
    if (s1_sign_q) begin
      res_s = ONE_Q - pos_s;
    end else begin
      res_s = pos_s;
    end
    if (s1_valid_q) begin
      out_val_d = {7'd0, res_s};
    end else begin
      out_val_d = out_val_q;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sat_q    <= 1'b0;
      s1_idx_q    <= 7'd0;
`ifdef SIGMOID_INTERP_EN
      s1_frac_q   <= 4'd0;
`endif
      out_valid_q <= 1'b0;
      out_val_q   <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_sat_q    <= s1_sat_d;
      s1_idx_q    <= s1_idx_d;
`ifdef SIGMOID_INTERP_EN
      s1_frac_q   <= s1_frac_d;
`endif
      out_valid_q <= out_valid_d;
      out_val_q   <= out_val_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_val   = out_val_q;

endmodule

// File: tb/tb_sigmoid_lut_q88.sv
// Scoreboard bench for sigmoid_lut_q88: stimulus pushes expectations, a
// monitor pops and compares whenever out_valid is high.
module tb_sigmoid_lut_q88;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_val;
  logic        out_valid;
  logic [15:0] out_val;

  always #5 clk = ~clk;

  sigmoid_lut_q88 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_val    (in_val),
    .out_valid (out_valid),
    .out_val   (out_val)
  );

  typedef struct {
    logic [15:0] x;
    bit          chk;
    int          expv;
    int          cyc;
    bit          cap;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_val = 0;
  int          lref [0:128];
  logic [15:0] cap_mem [0:65535];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: pop and compare on every valid output; otherwise output must hold.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      last_val = 0;
    end else if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out_val=%0d with nothing pending, expected no output", out_val);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check($sformatf("latency(x=%04h)", e.x), cyc, e.cyc + 2);
        check($sformatf("range(x=%04h)", e.x), (out_val <= 16'd256) ? 1 : 0, 1);
        if (e.chk) check($sformatf("out(x=%04h)", e.x), int'(out_val), e.expv);
        if (e.cap) cap_mem[e.x] = out_val;
        last_val = int'(out_val);
      end
    end else begin
      check("hold_when_idle", int'(out_val), last_val);
    end
  end

  task automatic send(input logic [15:0] x, input bit chk, input int expv, input bit cap);
    sb_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_val   = x;
    e.x = x; e.chk = chk; e.expv = expv; e.cyc = cyc; e.cap = cap;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_val   = 16'($urandom);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", sb_q.size(), 0);
    sb_q.delete();
  endtask

  logic [15:0] dir_x [0:8];
  int          dir_e [0:8];
  logic [15:0] tp_x  [0:4];
  int          tp_e  [0:4];
  logic [15:0] ip_x  [0:4];
  int          ip_e  [0:4];

  initial begin
    int prev;
    lref = '{128, 132, 136, 140, 144, 148, 152, 156, 159, 163, 167, 170, 174, 177, 181, 184,
             187, 190, 193, 196, 199, 202, 204, 207, 209, 212, 214, 216, 218, 220, 222, 224,
             225, 227, 229, 230, 232, 233, 234, 235, 237, 238, 239, 240, 241, 241, 242, 243,
             244, 245, 245, 246, 246, 247, 248, 248, 248, 249, 249, 250, 250, 250, 251, 251,
             251, 252, 252, 252, 252, 253, 253, 253, 253, 253, 254, 254, 254, 254, 254, 254,
             254, 254, 254, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255, 255,
             255, 255, 255, 255, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256,
             256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256,
             256};
    dir_x = '{16'hF800, 16'hFF00, 16'h0000, 16'h0100, 16'h0800, 16'h7FFF, 16'h8000, 16'h0FFF, 16'hF001};
    dir_e = '{0, 69, 128, 187, 256, 256, 0, 256, 0};
    tp_x  = '{16'h0000, 16'h0100, 16'hFF00, 16'h0800, 16'hF800};
    tp_e  = '{128, 187, 69, 256, 0};
`ifdef SIGMOID_INTERP_EN
    // 0x0108: 187 + (3*8 >> 4) = 188; 0x0008: 128 + (4*8 >> 4) = 130
    ip_x = '{16'h0108, 16'hFEF8, 16'h0008, 16'hFFF8, 16'h07FF};
    ip_e = '{lref[16] + (((lref[17] - lref[16]) * 8) >> 4), 68, 130, 126, 256};
`else
    ip_x = '{16'h0108, 16'hFEF8, 16'h0008, 16'hFFF8, 16'h07FF};
    ip_e = '{187, 69, 128, 128, 256};
`endif

    rst      = 1'b1;
    in_valid = 1'b0;
    in_val   = 16'd0;
    #3;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_val", int'(out_val), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed points and saturation extremes, one pulse at a time.
    for (int i = 0; i < 9; i++) begin
      send(dir_x[i], 1'b1, dir_e[i], 1'b0);
      idle();
      idle();
    end
    drain();

    // Back-to-back throughput.
    for (int i = 0; i < 5; i++) send(tp_x[i], 1'b1, tp_e[i], 1'b0);
    drain();

    // Off-grid points where the two builds differ.
    for (int i = 0; i < 5; i++) send(ip_x[i], 1'b1, ip_e[i], 1'b0);
    drain();

    // Every grid point on both sides against the reference table.
    for (int k = 0; k < 128; k++) begin
      send(16'(k * 16), 1'b1, lref[k], 1'b0);
      if (k > 0) send(16'(-(k * 16)), 1'b1, 256 - lref[k], 1'b0);
    end
    drain();

    // Symmetry and monotonicity sweep over (0, 8.0).
    for (int x = 1; x < 16'h0800; x++) begin
      send(16'(x), 1'b0, 0, 1'b1);
      send(16'(-x), 1'b0, 0, 1'b1);
    end
    drain();
    prev = 128;
    for (int x = 1; x < 16'h0800; x++) begin
      logic [15:0] px;
      logic [15:0] nx;
      px = 16'(x);
      nx = 16'(-x);
      check($sformatf("symmetry(x=%04h)", px), int'(cap_mem[px]) + int'(cap_mem[nx]), 256);
      check($sformatf("monotonic(x=%04h)", px), (int'(cap_mem[px]) >= prev) ? 1 : 0, 1);
      prev = int'(cap_mem[px]);
    end

    // Reset mid-stream with valid inputs in flight.
    for (int i = 0; i < 4; i++) send(16'h0100, 1'b1, 187, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_out_val", int'(out_val), 0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("post_reset_quiet", int'(out_valid), 0);
    end
    send(16'h0000, 1'b1, 128, 1'b0);
    drain();

    check("final_scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigmoid_lut_q88.md
Name: sigmoid_lut_q88

Overview:
Pipelined logistic-sigmoid approximator for the CNN activation stage. Takes a signed Q8.8 sample and returns sigmoid(x) in signed Q8.8, range 0 to 256 (0.0 to 1.0). Uses a 128-entry ROM over |x| in [0,8) plus odd symmetry, and saturates outside that range. Sits after the MAC/accumulator path, feeding the pooling and output layers.

Parameters:
DATA_W, 16, input and output width; fixed Q8.8, no other value supported.
LUT_DEPTH, 128, ROM entries; step 1/16 over [0,8).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  qualifies in_val for this cycle.
in_val  input  16  signed Q8.8 operand x.
out_valid  output  1  qualifies out_val.
out_val  output  16  signed Q8.8 sigmoid(x), always in 0..256.

Behaviour:
- One clock; reset is asynchronous and active-high.
- While rst is high: out_val = 0, out_valid = 0, all pipeline registers cleared. Anything in flight at reset is discarded.
- Pipeline has fixed latency of 2 cycles, with no stalls or backpressure. An input accepted on cycle N appears at out_valid/out_val on cycle N+2.
- out_valid is in_valid delayed by 2 cycles. out_val holds its last value when out_valid = 0.
- Stage 1 (registered):
  - sign = in_val[15].
  - mag = |in_val|, computed at 17 bits so -32768 does not overflow.
  - sat = (mag >= 0x0800).
  - idx = mag[10:4] (7 bits).
  - frac = mag[3:0].
- ROM contents: L[k] = round(256 * 1/(1+exp(-k/16))) for k = 0..127. L[0] = 128, L[16] = 187, L[127] = 256. L[128] is defined as 256 for interpolation.
- Stage 2 (registered), computes the positive half p:
  - p = 256 if sat, else the table value, interpolated or not as selected by the optional feature.
  - out_val = p if sign = 0, else 256 - p.
- Boundaries:
  - x = 0 gives 128.
  - x >= +8.0 gives 256.
  - x <= -8.0 gives 0, including x = -128.0 (0x8000).
  - Symmetry is exact: out(-x) = 256 - out(x) for every x except 0x8000, which has no positive counterpart.
- Back-to-back valid inputs are supported every cycle, and outputs come out in order.
- Output is never negative and never exceeds 256.

Optional Feature:
SIGMOID_INTERP_EN
- Defined: linear interpolation, p = L[idx] + (((L[idx+1] - L[idx]) * frac) >> 4). The product is unsigned and floor-truncated. Latency stays 2.
- Undefined: nearest-lower lookup, p = L[idx], and frac is ignored.
- On exact 1/16 grid points both builds give identical results.

Test Plan:
- Reset: assert rst mid-stream with in_valid = 1 -> out_valid = 0 and out_val = 0 immediately, without waiting for a clock; nothing emerges for 2 cycles after release.
- Directed points, with in_valid pulsed: 0xF800 (-8.0) -> 0; 0xFF00 (-1.0) -> 69; 0x0000 -> 128; 0x0100 (+1.0) -> 187; 0x0800 (+8.0) -> 256. Each appears 2 cycles after input.
- Saturation extremes: 0x7FFF -> 256; 0x8000 -> 0; 0x0FFF -> 256; 0xF001 -> 0.
- Throughput: 5 consecutive valid inputs 0x0000, 0x0100, 0xFF00, 0x0800, 0xF800 -> outputs 128, 187, 69, 256, 0 on 5 consecutive cycles starting 2 cycles after the first input.
- Symmetry sweep: all x in 0x0001..0x07FF -> out(x) + out(-x) = 256; out is monotonic non-decreasing in x.
- Interpolation: 0x0108 -> L[16] + ((L[17] - L[16]) * 8 >> 4) when SIGMOID_INTERP_EN is defined; -> 187 when it is not.
